// File: rtl/uart_tx.sv
// UART transmitter: start bit, 6/7/8 data bits LSB first, one stop bit.
// Bit timing comes from an external one-cycle Tick enable; each serial bit
// lasts TICKS_PER_BIT ticks. All outputs are registered.
module uart_tx #(
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic       Clk,
    input  logic       rst,
    input  logic       Tick,
    input  logic       TxEn,
    input  logic       TxStart,
    input  logic [3:0] NBits,
    input  logic [7:0] TxData,
    output logic       Tx,
    output logic       TxBusy,
    output logic       TxDone
);

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned CNT_W  = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [IDX_W-1:0]   bit_idx_q,  bit_idx_d;
    logic [IDX_W-1:0]   last_idx_q, last_idx_d;
    logic [DATA_W-1:0]  shift_q,    shift_d;
    logic               tx_q,       tx_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    logic [IDX_W-1:0]   req_last_idx_c;
    logic               bit_end_c;

    // Index of the final data bit for the requested width; unsupported widths send 8 bits
    always_comb begin
        case (NBits)
            4'd6:    req_last_idx_c = IDX_W'(5);
            4'd7:    req_last_idx_c = IDX_W'(6);
            default: req_last_idx_c = IDX_W'(7);
        endcase
    end

    // Last tick of the current serial bit
    assign bit_end_c = Tick && (tick_cnt_q == TICK_LAST);

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_idx_d  = bit_idx_q;
        last_idx_d = last_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (TxStart && TxEn) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                    bit_idx_d  = '0;
                    last_idx_d = req_last_idx_c;
                    shift_d    = TxData;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            START: begin
                if (bit_end_c) begin
                    state_d    = DATA;
                    tick_cnt_d = '0;
                    tx_d       = shift_q[0];
                end else if (Tick) begin
                    tick_cnt_d = CNT_W'(tick_cnt_q + 1'b1);
                end
            end

            DATA: begin
                if (bit_end_c) begin
                    tick_cnt_d = '0;
                    if (bit_idx_q == last_idx_q) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = IDX_W'(bit_idx_q + 1'b1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else if (Tick) begin
                    tick_cnt_d = CNT_W'(tick_cnt_q + 1'b1);
                end
            end

            STOP: begin
                if (bit_end_c) begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                    tx_d       = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else if (Tick) begin
                    tick_cnt_d = CNT_W'(tick_cnt_q + 1'b1);
                end
            end

            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line
    always_ff @(posedge Clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_idx_q  <= '0;
            last_idx_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_idx_q  <= bit_idx_d;
            last_idx_q <= last_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Tx     = tx_q;
    assign TxBusy = busy_q;
    assign TxDone = done_q;

endmodule
